// File: rtl/vmem_sequencer.sv
// Vector memory sequencer: walks the enabled lanes of one vector load/store
// and issues one scalar request per lane, then pulses done/vregWEN once.
module vmem_sequencer #(
  parameter int THREADS = 4,
  parameter int WORD_W  = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      start,
  input  logic                      isStore,
  input  logic [THREADS-1:0]        lane_en,
  input  logic [THREADS*WORD_W-1:0] lane_addr,
  input  logic [THREADS*WORD_W-1:0] lane_wdata,
  input  logic                      dhit,
  input  logic [WORD_W-1:0]         dmemload,
  output logic                      dmemREN,
  output logic                      dmemWEN,
  output logic [WORD_W-1:0]         dmemaddr,
  output logic [WORD_W-1:0]         dmemstore,
  output logic [THREADS*WORD_W-1:0] lane_rdata,
  output logic [THREADS-1:0]        vregWEN,
  output logic                      stall,
  output logic                      done
);

  localparam int LW = (THREADS > 1) ? $clog2(THREADS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state_q, state_d;
  logic [LW-1:0]      lane_q, lane_d;
  logic [LW-1:0]      first_lane, next_lane;
  logic               has_next;
  logic               store_q;
  logic [THREADS-1:0] en_q;
  logic [WORD_W-1:0]  addr_q  [THREADS];
  logic [WORD_W-1:0]  wdata_q [THREADS];
  logic [WORD_W-1:0]  rdata_q [THREADS];
  logic               in_access;

  // Downward scans so the lowest qualifying lane wins.
  always_comb begin
    first_lane = '0;
    for (int i = THREADS - 1; i >= 0; i--) begin
      if (lane_en[i]) first_lane = LW'(i);
    end
  end

  always_comb begin
    next_lane = '0;
    has_next  = 1'b0;
    for (int i = THREADS - 1; i >= 0; i--) begin
      if (en_q[i] && (i > int'(lane_q))) begin
        next_lane = LW'(i);
        has_next  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (|lane_en) begin
            state_d = ACCESS;
            lane_d  = first_lane;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACCESS: begin
        if (dhit) begin
          if (has_next) lane_d = next_lane;
          else          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      lane_q  <= '0;
      store_q <= 1'b0;
      en_q    <= '0;
      for (int i = 0; i < THREADS; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        rdata_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      if (state_q == IDLE && start) begin
        store_q <= isStore;
        en_q    <= lane_en;
        for (int i = 0; i < THREADS; i++) begin
          addr_q[i]  <= lane_addr[i*WORD_W +: WORD_W];
          wdata_q[i] <= lane_wdata[i*WORD_W +: WORD_W];
        end
      end
      if (state_q == ACCESS && dhit && !store_q) rdata_q[lane_q] <= dmemload;
    end
  end

  assign in_access = (state_q == ACCESS);
  assign dmemREN   = in_access & ~store_q;
  assign dmemWEN   = in_access & store_q;
  assign dmemaddr  = in_access ? (addr_q[lane_q] & ~WORD_W'(3)) : '0;
  assign dmemstore = in_access ? wdata_q[lane_q] : '0;
  assign done      = (state_q == DONE);
  assign vregWEN   = (state_q == DONE && !store_q) ? en_q : '0;
  assign stall     = in_access | ((state_q == IDLE) & start);

  for (genvar gi = 0; gi < THREADS; gi++) begin : g_rdata
    assign lane_rdata[gi*WORD_W +: WORD_W] = rdata_q[gi];
  end

endmodule

// File: tb/tb_vmem_sequencer.sv
// Self-checking bench: table of directed vector ops plus random ops, with the
// bench acting as memory and tracking expected lane data per lane.
module tb_vmem_sequencer;
  localparam int T = 4;
  localparam int W = 32;

  logic           CLK = 1'b0;
  logic           RST, start, isStore, dhit;
  logic [T-1:0]   lane_en;
  logic [T*W-1:0] lane_addr, lane_wdata;
  logic [W-1:0]   dmemload;
  logic           dmemREN, dmemWEN, stall, done;
  logic [W-1:0]   dmemaddr, dmemstore;
  logic [T*W-1:0] lane_rdata;
  logic [T-1:0]   vregWEN;

  vmem_sequencer #(.THREADS(T), .WORD_W(W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .isStore(isStore), .lane_en(lane_en),
    .lane_addr(lane_addr), .lane_wdata(lane_wdata), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .lane_rdata(lane_rdata), .vregWEN(vregWEN), .stall(stall), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic             st;
    logic [3:0]       en;
    logic [3:0][31:0] addr;
    logic [3:0][31:0] wdata;
    logic [3:0][31:0] ld;
    logic [3:0][3:0]  waits;
    int               rst_after;
    logic             busy;
    logic             chk_exp;
    logic [127:0]     exp_rdata;
  } vec_t;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] rdata_m [4];
  vec_t        tbl [6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [127:0] model_rdata();
    return {rdata_m[3], rdata_m[2], rdata_m[1], rdata_m[0]};
  endfunction

  function automatic vec_t blank();
    vec_t v;
    v.st = 1'b0; v.en = '0; v.addr = '0; v.wdata = '0; v.ld = '0; v.waits = '0;
    v.rst_after = -1; v.busy = 1'b0; v.chk_exp = 1'b0; v.exp_rdata = '0;
    return v;
  endfunction

  // Busy ops keep hammering start with a different instruction; it must be ignored.
  task automatic drive_side(input vec_t v);
    if (v.busy) begin
      start      = 1'b1;
      isStore    = ~v.st;
      lane_en    = ~v.en;
      lane_addr  = {$urandom, $urandom, $urandom, $urandom};
      lane_wdata = {$urandom, $urandom, $urandom, $urandom};
    end else begin
      start = 1'b0;
    end
  endtask

  task automatic run_op(input vec_t v);
    int lanes[$];
    int ndone;
    for (int i = 0; i < T; i++) if (v.en[i]) lanes.push_back(i);
    start = 1'b1; isStore = v.st; lane_en = v.en;
    lane_addr = v.addr; lane_wdata = v.wdata; dhit = 1'b0; dmemload = $urandom;
    #1;
    $display("op st=%0d en=%b waits=%h rst_after=%0d busy=%0d", v.st, v.en, v.waits, v.rst_after, v.busy);
    chk("idle_stall", 128'(stall), 128'(1));
    chk("idle_req", 128'({dmemREN, dmemWEN}), 128'(0));
    chk("idle_done", 128'({done, vregWEN}), 128'(0));
    tick();
    ndone = 0;
    foreach (lanes[k]) begin
      int l;
      l = lanes[k];
      for (int w = 0; w <= int'(v.waits[l]); w++) begin
        drive_side(v);
        dhit     = (w == int'(v.waits[l]));
        dmemload = dhit ? v.ld[l] : $urandom;
        #1;
        chk("req_ren", 128'(dmemREN), 128'(!v.st));
        chk("req_wen", 128'(dmemWEN), 128'(v.st));
        chk("req_addr", 128'(dmemaddr), 128'(v.addr[l] & 32'hFFFF_FFFC));
        if (v.st) chk("req_wdata", 128'(dmemstore), 128'(v.wdata[l]));
        chk("req_stall", 128'(stall), 128'(1));
        chk("req_done", 128'({done, vregWEN}), 128'(0));
        tick();
      end
      if (!v.st) rdata_m[l] = v.ld[l];
      ndone++;
      if (ndone == v.rst_after) begin
        start = 1'b0; dhit = 1'b0; RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int i = 0; i < T; i++) rdata_m[i] = '0;
        #1;
        chk("rst_req", 128'({dmemREN, dmemWEN}), 128'(0));
        chk("rst_done", 128'({done, vregWEN}), 128'(0));
        chk("rst_rdata", lane_rdata, model_rdata());
        chk("rst_stall", 128'(stall), 128'(0));
        tick();
        chk("rst_done2", 128'({done, vregWEN}), 128'(0));
        if (v.chk_exp) chk("table_rdata", lane_rdata, v.exp_rdata);
        return;
      end
    end
    drive_side(v);
    dhit = 1'($urandom); dmemload = $urandom;
    #1;
    chk("done_pulse", 128'(done), 128'(1));
    chk("done_vreg", 128'(vregWEN), 128'(v.st ? 4'b0 : v.en));
    chk("done_stall", 128'(stall), 128'(0));
    chk("done_req", 128'({dmemREN, dmemWEN}), 128'(0));
    chk("done_rdata", lane_rdata, model_rdata());
    tick();
    start = 1'b0; dhit = 1'b0;
    if (v.chk_exp) chk("table_rdata", lane_rdata, v.exp_rdata);
  endtask

  initial begin
    vec_t v;
    RST = 1'b1; start = 1'b0; isStore = 1'b0; lane_en = '0; lane_addr = '0;
    lane_wdata = '0; dhit = 1'b0; dmemload = '0;
    for (int i = 0; i < T; i++) rdata_m[i] = '0;
    tick(); tick();
    chk("reset_req", 128'({dmemREN, dmemWEN}), 128'(0));
    chk("reset_addr", 128'({dmemaddr, dmemstore}), 128'(0));
    chk("reset_rdata", lane_rdata, 128'(0));
    chk("reset_done", 128'({done, vregWEN, stall}), 128'(0));
    RST = 1'b0;
    tick();

    // Directed table
    v = blank(); v.en = 4'b1111; v.chk_exp = 1'b1;
    v.addr = {32'h10C, 32'h108, 32'h104, 32'h100};
    v.ld   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    v.exp_rdata = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    tbl[0] = v;
    v = blank(); v.st = 1'b1; v.en = 4'b1010; v.chk_exp = 1'b1;
    v.addr = {32'h300, 32'h0, 32'h203, 32'h0};
    v.wdata = {32'hBEEF, 32'h0, 32'hDEAD, 32'h0};
    v.waits = {4'd2, 4'd0, 4'd2, 4'd0};
    v.exp_rdata = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    tbl[1] = v;
    v = blank(); v.chk_exp = 1'b1;
    v.exp_rdata = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    tbl[2] = v;
    v = blank(); v.en = 4'b1111; v.rst_after = 2; v.chk_exp = 1'b1;
    v.addr = {32'h50C, 32'h508, 32'h504, 32'h500};
    v.ld   = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    v.waits = {4'd1, 4'd0, 4'd1, 4'd0};
    tbl[3] = v;
    v = blank(); v.en = 4'b0110; v.busy = 1'b1; v.chk_exp = 1'b1;
    v.addr = {32'h0, 32'h612, 32'h601, 32'h0};
    v.ld   = {32'h0, 32'h22, 32'h11, 32'h0};
    v.waits = {4'd0, 4'd1, 4'd1, 4'd0};
    v.exp_rdata = {32'h0, 32'h22, 32'h11, 32'h0};
    tbl[4] = v;
    v = blank(); v.st = 1'b1; v.en = 4'b0001; v.chk_exp = 1'b1;
    v.addr = {32'h0, 32'h0, 32'h0, 32'h401};
    v.wdata = {32'h0, 32'h0, 32'h0, 32'h1234};
    v.exp_rdata = {32'h0, 32'h22, 32'h11, 32'h0};
    tbl[5] = v;

    for (int i = 0; i < 6; i++) run_op(tbl[i]);

    // Spurious dhit while idle must not touch any lane state
    dhit = 1'b1; dmemload = 32'h55;
    #1;
    chk("spur_done", 128'({done, vregWEN}), 128'(0));
    tick();
    chk("spur_rdata", lane_rdata, model_rdata());
    chk("spur_done2", 128'({done, vregWEN}), 128'(0));
    dhit = 1'b0;
    $display("spurious dhit idle rdata=%h", lane_rdata);

    // Random ops against the lane model
    for (int n = 0; n < 40; n++) begin
      v = blank();
      v.st    = 1'($urandom);
      v.en    = 4'($urandom);
      v.addr  = {$urandom, $urandom, $urandom, $urandom};
      v.wdata = {$urandom, $urandom, $urandom, $urandom};
      v.ld    = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < T; i++) v.waits[i] = 4'($urandom_range(0, 2));
      v.busy  = 1'($urandom);
      if ($countones(v.en) > 0 && $urandom_range(0, 7) == 0)
        v.rst_after = $urandom_range(1, $countones(v.en));
      run_op(v);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
